// File: rtl/hdb3_decoder.sv
// -----------------------------------------------------------------------------
// hdb3_decoder
//
// Receive-side HDB3 decoder. Takes one bipolar symbol per accepted cycle and
// restores the NRZ bit stream. Substitution pulses are recognised as
// polarity violations (V). V itself decodes as 0. The companion B pulse
// three symbols earlier is removed while it is still inside a 4-symbol
// alignment buffer. Every decoded bit therefore leaves with a fixed latency
// of four accepted symbols. The block also flags coding violations.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous, active-high reset
//   in_valid    a symbol is presented on code_in this cycle
//   code_in     bipolar symbol: 00 = 0, 01 = +1, 11 = -1, 10 = illegal
//   data_out    decoded NRZ bit, qualified by data_valid
//   data_valid  data_out carries a decoded bit this cycle
//   code_err    one-cycle pulse after a symbol that violates the line code
// -----------------------------------------------------------------------------
module hdb3_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] code_in,
    output logic       data_out,
    output logic       data_valid,
    output logic       code_err
);

    // Alignment buffer: bit 0 is the newest symbol, bit 3 the oldest.
    logic [3:0] d;
    logic [3:0] v;

    // Polarity history and zero-run tracking.
    logic       last_pol;
    logic       have_pol;
    logic [1:0] zrun;

    // Per-symbol classification of the symbol on code_in.
    logic pulse;
    logic pol;
    logic is_v;
    logic is_zero;
    logic bit_dec;
    logic err_next;

    // Classify the incoming symbol. A pulse with the same polarity as the
    // previous pulse is a violation (V). The very first pulse after reset
    // has no history, so it is always taken as a mark. The illegal code 10
    // counts as a zero for decoding and for the zero-run check.
    always_comb begin
        pulse    = 1'b0;
        pol      = 1'b0;
        is_v     = 1'b0;
        is_zero  = 1'b0;
        bit_dec  = 1'b0;
        err_next = 1'b0;

        pulse   = (code_in == 2'b01) || (code_in == 2'b11);
        pol     = code_in[1];
        is_zero = ~pulse;
        is_v    = pulse & have_pol & (pol == last_pol);
        bit_dec = pulse & ~is_v;

        // Three causes of a violation share one error pulse: an illegal
        // code, a fourth zero in a row, and a V whose two preceding symbols
        // are not both zero.
        err_next = (code_in == 2'b10)
                 | (is_zero & (zrun == 2'd3))
                 | (is_v & (d[0] | d[1]));
    end

    // Symbol-rate state. Everything advances only on accepted symbols.
    // On a V, the entry moving into the last stage is the symbol three
    // positions earlier. That is the B (or 0) slot of the substitution, so
    // it is forced to 0 on its way out.
    always_ff @(posedge clk) begin
        if (rst) begin
            d          <= 4'b0000;
            v          <= 4'b0000;
            last_pol   <= 1'b0;
            have_pol   <= 1'b0;
            zrun       <= 2'd0;
            data_out   <= 1'b0;
            data_valid <= 1'b0;
            code_err   <= 1'b0;
        end else if (in_valid) begin
            d          <= {(is_v ? 1'b0 : d[2]), d[1], d[0], bit_dec};
            v          <= {v[2:0], 1'b1};
            data_out   <= d[3];
            data_valid <= v[3];
            code_err   <= err_next;
            if (pulse) begin
                last_pol <= pol;
                have_pol <= 1'b1;
                zrun     <= 2'd0;
            end else if (zrun != 2'd3) begin
                zrun <= zrun + 2'd1;
            end
        end else begin
            data_valid <= 1'b0;
            code_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hdb3_decoder.sv
// -----------------------------------------------------------------------------
// tb_hdb3_decoder
//
// Self-checking bench for hdb3_decoder. Directed vectors carry hand-computed
// expected outputs. Each row is applied for one clock and the registered
// outputs are compared just after the edge. A hand-written sequence covers
// in_valid gaps.
// -----------------------------------------------------------------------------
module tb_hdb3_decoder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] code_in;
    logic       data_out;
    logic       data_valid;
    logic       code_err;

    int total;
    int bad;

    typedef struct {
        logic       rst;
        logic       in_valid;
        logic [1:0] code;
        logic       exp_valid;
        logic       exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    hdb3_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .code_in    (code_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .code_err   (code_err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Queue one table row.
    task automatic add_vec(input logic r, input logic iv, input logic [1:0] c,
                           input logic ev, input logic ed, input logic ee);
        vec_t t;
        t.rst       = r;
        t.in_valid  = iv;
        t.code      = c;
        t.exp_valid = ev;
        t.exp_data  = ed;
        t.exp_err   = ee;
        vecs.push_back(t);
    endtask

    // Drive inputs, advance one edge, then settle away from the edge.
    task automatic apply_stimulus(input logic r, input logic iv, input logic [1:0] c);
        rst      = r;
        in_valid = iv;
        code_in  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int idx,
                                input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s step %0d: got %b, expected %b", name, idx, actual, expected);
        end
    endtask

    logic [1:0] tog_codes [6];

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        code_in  = 2'b00;
        #2;

        // Plain alternating marks followed by four zeros.
        add_vec(1, 0, 2'b00, 0, 0, 0);
        add_vec(0, 1, 2'b01, 0, 0, 0);
        add_vec(0, 1, 2'b11, 0, 0, 0);
        add_vec(0, 1, 2'b01, 0, 0, 0);
        add_vec(0, 1, 2'b11, 0, 0, 0);
        add_vec(0, 1, 2'b00, 1, 1, 0);
        add_vec(0, 1, 2'b00, 1, 1, 0);
        add_vec(0, 1, 2'b00, 1, 1, 0);
        add_vec(0, 1, 2'b00, 1, 1, 1);

        // 000V, then B00V, then a 4-zero flush.
        add_vec(1, 0, 2'b00, 0, 0, 0);
        add_vec(0, 1, 2'b01, 0, 0, 0);
        add_vec(0, 1, 2'b00, 0, 0, 0);
        add_vec(0, 1, 2'b00, 0, 0, 0);
        add_vec(0, 1, 2'b00, 0, 0, 0);
        add_vec(0, 1, 2'b01, 1, 1, 0);
        add_vec(0, 1, 2'b11, 1, 0, 0);
        add_vec(0, 1, 2'b00, 1, 0, 0);
        add_vec(0, 1, 2'b00, 1, 0, 0);
        add_vec(0, 1, 2'b11, 1, 0, 0);
        add_vec(0, 1, 2'b00, 1, 0, 0);
        add_vec(0, 1, 2'b00, 1, 0, 0);
        add_vec(0, 1, 2'b00, 1, 0, 0);
        add_vec(0, 1, 2'b00, 1, 0, 1);

        // Two V pulses, each with a nonzero symbol in the two slots before it.
        add_vec(1, 0, 2'b00, 0, 0, 0);
        add_vec(0, 1, 2'b01, 0, 0, 0);
        add_vec(0, 1, 2'b01, 0, 0, 1);
        add_vec(0, 1, 2'b00, 0, 0, 0);
        add_vec(0, 1, 2'b11, 0, 0, 0);
        add_vec(0, 1, 2'b00, 1, 1, 0);
        add_vec(0, 1, 2'b11, 1, 0, 1);
        add_vec(0, 1, 2'b00, 1, 0, 0);
        add_vec(0, 1, 2'b00, 1, 1, 0);
        add_vec(0, 1, 2'b00, 1, 0, 0);

        // Illegal code 10 decodes as 0 and pulses code_err.
        add_vec(1, 0, 2'b00, 0, 0, 0);
        add_vec(0, 1, 2'b01, 0, 0, 0);
        add_vec(0, 1, 2'b10, 0, 0, 1);
        add_vec(0, 1, 2'b11, 0, 0, 0);
        add_vec(0, 1, 2'b00, 0, 0, 0);
        add_vec(0, 1, 2'b00, 1, 1, 0);
        add_vec(0, 1, 2'b00, 1, 0, 0);
        add_vec(0, 1, 2'b00, 1, 1, 1);

        // Reset mid-stream while in_valid is high. The next 11 is a mark.
        add_vec(1, 0, 2'b00, 0, 0, 0);
        add_vec(0, 1, 2'b01, 0, 0, 0);
        add_vec(0, 1, 2'b11, 0, 0, 0);
        add_vec(0, 1, 2'b01, 0, 0, 0);
        add_vec(1, 1, 2'b01, 0, 0, 0);
        add_vec(0, 1, 2'b11, 0, 0, 0);
        add_vec(0, 1, 2'b00, 0, 0, 0);
        add_vec(0, 1, 2'b00, 0, 0, 0);
        add_vec(0, 1, 2'b00, 0, 0, 0);
        add_vec(0, 1, 2'b00, 1, 1, 1);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].in_valid, vecs[i].code);
            check_output("data_valid", i, data_valid, vecs[i].exp_valid);
            check_output("code_err", i, code_err, vecs[i].exp_err);
            if (vecs[i].exp_valid || vecs[i].rst)
                check_output("data_out", i, data_out, vecs[i].exp_data);
        end

        // in_valid gaps: an illegal code on idle cycles must be ignored, and
        // latency counts accepted symbols only.
        tog_codes = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11};
        apply_stimulus(1, 0, 2'b00);
        check_output("gap_reset_valid", 0, data_valid, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            apply_stimulus(0, 1, tog_codes[k-1]);
            check_output("gap_acc_valid", k, data_valid, (k >= 5) ? 1'b1 : 1'b0);
            check_output("gap_acc_err", k, code_err, 1'b0);
            if (k >= 5)
                check_output("gap_acc_data", k, data_out, 1'b1);
            apply_stimulus(0, 0, 2'b10);
            check_output("gap_idle_valid", k, data_valid, 1'b0);
            check_output("gap_idle_err", k, code_err, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
